tb_dina_seq: RTL and testbench

- Command-driven sequencer for the TB port-A write path.
- Accepts one transfer command at a time and generates source read strobes (CB port A or TB port B) with addresses.
- Drives the TB dina mux controls (TB_dina_sel, l_k_0, seq_cnt_out) aligned to source read latency, then the TB port-A write enable/address aligned to the mux's 1-cycle registered output.
- Sits between the top-level EKF stage FSM and the TB dina mux / TB BRAM.

---
 rtl/tb_dina_seq_if.sv | 35 +++
 rtl/tb_dina_seq.sv | 203 ++++++++++++++++++++
 tb/tb_tb_dina_seq.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tb_dina_seq_if.sv
// ---------------------------------------------------------------------------
// tb_dina_seq_if
// Command handshake between the EKF stage FSM (master) and the TB port-A
// write sequencer (slave).
//   cmd_valid    master -> slave  command request
//   cmd_ready    slave  -> master high while the sequencer is idle
//   cmd_op       master -> slave  0=CB_POS 1=CB_NEG 2=CB_NEW 3=TB_COPY 4=VT_WR
//   cmd_len      master -> slave  beat count (ignored for VT_WR)
//   cmd_src_addr master -> slave  source base row
//   cmd_dst_addr master -> slave  TB destination base row
//   cmd_lk0      master -> slave  half select for CB_NEW
//   done         slave  -> master 1-cycle pulse at end of command
// ---------------------------------------------------------------------------
interface tb_dina_seq_if #(
  parameter int AW = 10
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_len;
  logic [AW-1:0] cmd_src_addr;
  logic [AW-1:0] cmd_dst_addr;
  logic          cmd_lk0;
  logic          done;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_src_addr, cmd_dst_addr, cmd_lk0,
    input  cmd_ready, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_src_addr, cmd_dst_addr, cmd_lk0,
    output cmd_ready, done
  );
endinterface

// File: rtl/tb_dina_seq.sv
// ---------------------------------------------------------------------------
// tb_dina_seq
// Command-driven sequencer for the TB port-A write path. One command at a
// time: issues one source read strobe per beat (CB port A or TB port B),
// delivers the dina mux controls RD_LAT cycles later, and the TB port-A
// write enable/address one cycle after that (the mux output is registered).
// Ports:
//   clk, sys_rst_n        clock, asynchronous active-low reset
//   cmd                   command handshake (slave side)
//   CB_ena / CB_addra     CB port-A read strobe and row
//   TB_enb / TB_addrb     TB port-B read strobe and row
//   TB_dina_sel, l_k_0,
//   seq_cnt_out           dina mux controls (zero when no beat is present)
//   TB_wea / TB_addra     TB port-A write strobe and row (row holds when idle)
// ---------------------------------------------------------------------------
module tb_dina_seq #(
  parameter int AW             = 10,
  parameter int RD_LAT         = 1,
  parameter int SEQ_CNT_DW     = 5,
  parameter int TB_DINA_SEL_DW = 5
) (
  input  logic                      clk,
  input  logic                      sys_rst_n,
  tb_dina_seq_if.slave              cmd,
  output logic                      CB_ena,
  output logic [AW-1:0]             CB_addra,
  output logic                      TB_enb,
  output logic [AW-1:0]             TB_addrb,
  output logic [TB_DINA_SEL_DW-1:0] TB_dina_sel,
  output logic                      l_k_0,
  output logic [SEQ_CNT_DW-1:0]     seq_cnt_out,
  output logic                      TB_wea,
  output logic [AW-1:0]             TB_addra
);

  localparam logic [2:0] OP_CB_POS  = 3'd0;
  localparam logic [2:0] OP_CB_NEG  = 3'd1;
  localparam logic [2:0] OP_CB_NEW  = 3'd2;
  localparam logic [2:0] OP_TB_COPY = 3'd3;
  localparam logic [2:0] OP_VT_WR   = 3'd4;

  localparam int            DRW = $clog2(RD_LAT + 1) + 1;
  localparam logic [DRW-1:0] DRAIN_FULL  = DRW'(RD_LAT);
  localparam logic [DRW-1:0] DRAIN_EMPTY = DRW'(RD_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  function automatic logic [TB_DINA_SEL_DW-1:0] sel_of(input logic [2:0] op);
    logic [TB_DINA_SEL_DW-1:0] s;
    s = '0;
    case (op)
      OP_CB_POS:  s = TB_DINA_SEL_DW'(5'b10001);
      OP_CB_NEG:  s = TB_DINA_SEL_DW'(5'b10010);
      OP_CB_NEW:  s = TB_DINA_SEL_DW'(5'b10011);
      OP_TB_COPY: s = TB_DINA_SEL_DW'(5'b10100);
      OP_VT_WR:   s = TB_DINA_SEL_DW'(5'b11100);
      default:    s = '0;
    endcase
    return s;
  endfunction

  state_t         state_q, state_d;
  logic [AW-1:0]  k_q, k_d;
  logic [DRW-1:0] drain_q, drain_d;

  // Latched command
  logic [2:0]    op_q;
  logic [AW-1:0] n_q, src_q, dst_q;
  logic          lk0_q;
  logic          beats_q;   // command has at least one beat

  logic          accept;
  logic          acc_legal, acc_vt;
  logic [AW-1:0] acc_n;
  logic          beat;

  // Control pipeline, entry [0] written by the issuing beat
  logic [RD_LAT-1:0]                     pvld_q;
  logic [RD_LAT-1:0][TB_DINA_SEL_DW-1:0] psel_q;
  logic [RD_LAT-1:0]                     plk_q;
  logic [RD_LAT-1:0][SEQ_CNT_DW-1:0]     pseq_q;
  logic [RD_LAT-1:0][AW-1:0]             pdst_q;

  logic          wea_q;
  logic [AW-1:0] waddr_q;

  assign accept    = (state_q == S_IDLE) && cmd.cmd_valid;
  assign acc_legal = (cmd.cmd_op <= OP_VT_WR);
  assign acc_vt    = (cmd.cmd_op == OP_VT_WR);
  assign acc_n     = acc_vt ? AW'(2) : cmd.cmd_len;

  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign cmd.done      = (state_q == S_DONE);

  // ---- Issue stage: read strobes straight from the FSM ----
  assign beat     = (state_q == S_ISSUE) && beats_q;
  assign CB_ena   = beat && (op_q <= OP_CB_NEW);
  assign TB_enb   = beat && (op_q == OP_TB_COPY);
  assign CB_addra = CB_ena ? (src_q + k_q) : '0;
  assign TB_addrb = TB_enb ? (src_q + k_q) : '0;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      drain_q <= '0;
      op_q    <= '0;
      n_q     <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      lk0_q   <= 1'b0;
      beats_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      drain_q <= drain_d;
      if (accept) begin
        op_q    <= cmd.cmd_op;
        n_q     <= acc_n;
        src_q   <= cmd.cmd_src_addr;
        dst_q   <= cmd.cmd_dst_addr;
        lk0_q   <= cmd.cmd_lk0;
        // Illegal opcodes behave as an empty command
        beats_q <= acc_legal && (acc_n != '0);
      end
    end
  end

  // DRAIN lasts RD_LAT+1 cycles after a real last beat (pipeline plus the
  // write stage), but only RD_LAT cycles for an empty command, since its
  // single ISSUE cycle already stands in for one beat slot.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ISSUE;
          k_d     = '0;
        end
      end
      S_ISSUE: begin
        if (!beats_q || (k_q == n_q - AW'(1))) begin
          state_d = S_DRAIN;
          k_d     = '0;
          drain_d = beats_q ? DRAIN_FULL : DRAIN_EMPTY;
        end else begin
          k_d = k_q + AW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_DONE;
        else               drain_d = drain_q - DRW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---- Mux-control pipeline: RD_LAT stages aligned to source read data ----
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pvld_q <= '0;
      psel_q <= '0;
      plk_q  <= '0;
      pseq_q <= '0;
      pdst_q <= '0;
    end else begin
      pvld_q[0] <= beat;
      psel_q[0] <= beat ? sel_of(op_q) : '0;
      plk_q[0]  <= beat && (op_q == OP_CB_NEW) && lk0_q;
      pseq_q[0] <= (beat && (op_q == OP_VT_WR)) ? SEQ_CNT_DW'(k_q + AW'(1)) : '0;
      pdst_q[0] <= beat ? (dst_q + k_q) : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        pvld_q[i] <= pvld_q[i-1];
        psel_q[i] <= psel_q[i-1];
        plk_q[i]  <= plk_q[i-1];
        pseq_q[i] <= pseq_q[i-1];
        pdst_q[i] <= pdst_q[i-1];
      end
    end
  end

  assign TB_dina_sel = psel_q[RD_LAT-1];
  assign l_k_0       = plk_q[RD_LAT-1];
  assign seq_cnt_out = pseq_q[RD_LAT-1];

  // ---- Write stage: one cycle behind the registered mux output ----
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wea_q   <= 1'b0;
      waddr_q <= '0;
    end else begin
      wea_q <= pvld_q[RD_LAT-1];
      if (pvld_q[RD_LAT-1]) waddr_q <= pdst_q[RD_LAT-1];
    end
  end

  assign TB_wea   = wea_q;
  assign TB_addra = waddr_q;

endmodule

// File: tb/tb_tb_dina_seq.sv
module tb_tb_dina_seq;
  localparam int AW   = 10;
  localparam int TMAX = 24;

  localparam logic [2:0] CB_POS  = 3'd0;
  localparam logic [2:0] CB_NEG  = 3'd1;
  localparam logic [2:0] CB_NEW  = 3'd2;
  localparam logic [2:0] TB_COPY = 3'd3;
  localparam logic [2:0] VT_WR   = 3'd4;

  logic clk = 1'b0;
  logic sys_rst_n;
  always #5 clk = ~clk;

  tb_dina_seq_if #(.AW(AW)) if1 ();
  tb_dina_seq_if #(.AW(AW)) if2 ();

  logic          cb_ena1, tb_enb1, lk1, wea1;
  logic [AW-1:0] cb_addra1, tb_addrb1, waddra1;
  logic [4:0]    sel1, seq1;
  logic          cb_ena2, tb_enb2, lk2, wea2;
  logic [AW-1:0] cb_addra2, tb_addrb2, waddra2;
  logic [4:0]    sel2, seq2;

  tb_dina_seq #(.AW(AW), .RD_LAT(1), .SEQ_CNT_DW(5), .TB_DINA_SEL_DW(5)) dut1 (
    .clk(clk), .sys_rst_n(sys_rst_n), .cmd(if1),
    .CB_ena(cb_ena1), .CB_addra(cb_addra1), .TB_enb(tb_enb1), .TB_addrb(tb_addrb1),
    .TB_dina_sel(sel1), .l_k_0(lk1), .seq_cnt_out(seq1),
    .TB_wea(wea1), .TB_addra(waddra1)
  );

  tb_dina_seq #(.AW(AW), .RD_LAT(2), .SEQ_CNT_DW(5), .TB_DINA_SEL_DW(5)) dut2 (
    .clk(clk), .sys_rst_n(sys_rst_n), .cmd(if2),
    .CB_ena(cb_ena2), .CB_addra(cb_addra2), .TB_enb(tb_enb2), .TB_addrb(tb_addrb2),
    .TB_dina_sel(sel2), .l_k_0(lk2), .seq_cnt_out(seq2),
    .TB_wea(wea2), .TB_addra(waddra2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic          t_cbena[TMAX], t_tbenb[TMAX], t_lk[TMAX], t_wea[TMAX], t_done[TMAX], t_ready[TMAX];
  logic [AW-1:0] t_cbaddr[TMAX], t_tbaddrb[TMAX], t_waddr[TMAX];
  logic [4:0]    t_sel[TMAX], t_seq[TMAX];

  // Packed view of one cycle; addresses only matter while their strobe is high
  function automatic logic [45:0] obs(input int c);
    return {t_cbena[c], t_cbena[c] ? t_cbaddr[c] : 10'd0,
            t_tbenb[c], t_tbenb[c] ? t_tbaddrb[c] : 10'd0,
            t_sel[c], t_lk[c], t_seq[c],
            t_wea[c], t_wea[c] ? t_waddr[c] : 10'd0,
            t_done[c], t_ready[c]};
  endfunction

  function automatic logic [45:0] pk(input logic cbe, input logic [9:0] cba,
                                     input logic tbe, input logic [9:0] tba,
                                     input logic [4:0] sel, input logic lk,
                                     input logic [4:0] seq, input logic we,
                                     input logic [9:0] wa, input logic dn,
                                     input logic rdy);
    return {cbe, cba, tbe, tba, sel, lk, seq, we, wa, dn, rdy};
  endfunction

  function automatic logic [45:0] raw(input int which);
    if (which == 1)
      return {cb_ena1, cb_addra1, tb_enb1, tb_addrb1, sel1, lk1, seq1, wea1, waddra1, if1.done, if1.cmd_ready};
    return {cb_ena2, cb_addra2, tb_enb2, tb_addrb2, sel2, lk2, seq2, wea2, waddra2, if2.done, if2.cmd_ready};
  endfunction

  task automatic sample(input int which, input int c);
    if (which == 1) begin
      t_cbena[c] = cb_ena1; t_cbaddr[c] = cb_addra1; t_tbenb[c] = tb_enb1; t_tbaddrb[c] = tb_addrb1;
      t_sel[c] = sel1; t_lk[c] = lk1; t_seq[c] = seq1; t_wea[c] = wea1; t_waddr[c] = waddra1;
      t_done[c] = if1.done; t_ready[c] = if1.cmd_ready;
    end else begin
      t_cbena[c] = cb_ena2; t_cbaddr[c] = cb_addra2; t_tbenb[c] = tb_enb2; t_tbaddrb[c] = tb_addrb2;
      t_sel[c] = sel2; t_lk[c] = lk2; t_seq[c] = seq2; t_wea[c] = wea2; t_waddr[c] = waddra2;
      t_done[c] = if2.done; t_ready[c] = if2.cmd_ready;
    end
  endtask

  task automatic drive_cmd(input int which, input logic v, input logic [2:0] op,
                           input logic [AW-1:0] len, input logic [AW-1:0] src,
                           input logic [AW-1:0] dst, input logic lk);
    if (which == 1) begin
      if1.cmd_valid = v; if1.cmd_op = op; if1.cmd_len = len;
      if1.cmd_src_addr = src; if1.cmd_dst_addr = dst; if1.cmd_lk0 = lk;
    end else begin
      if2.cmd_valid = v; if2.cmd_op = op; if2.cmd_len = len;
      if2.cmd_src_addr = src; if2.cmd_dst_addr = dst; if2.cmd_lk0 = lk;
    end
  endtask

  // Presents a command for one cycle (C0) and records cycles C1..ncyc
  task automatic run_cmd(input int which, input logic [2:0] op, input logic [AW-1:0] len,
                         input logic [AW-1:0] src, input logic [AW-1:0] dst,
                         input logic lk, input int ncyc);
    @(posedge clk); #1;
    drive_cmd(which, 1'b1, op, len, src, dst, lk);
    @(posedge clk); #1;
    drive_cmd(which, 1'b0, 3'd0, '0, '0, '0, 1'b0);
    for (int c = 1; c <= ncyc; c++) begin
      sample(which, c);
      if (c < ncyc) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int w = 1; w <= 2; w++) begin
      n_tests++;
      if (raw(w) !== 46'd1) begin
        n_fail++; $display("FAIL reset dut%0d got %h exp %h", w, raw(w), 46'd1);
      end
    end
    sys_rst_n = 1'b1;
  endtask

  task automatic test_cb_pos();
    logic [45:0] ex;
    logic cb, we;
    run_cmd(1, CB_POS, 10'd4, 10'd8, 10'h20, 1'b0, 9);
    for (int c = 1; c <= 9; c++) begin
      cb = (c >= 1 && c <= 4);
      we = (c >= 3 && c <= 6);
      ex = pk(cb, cb ? 10'(8 + c - 1) : 10'd0, 1'b0, 10'd0,
              (c >= 2 && c <= 5) ? 5'b10001 : 5'd0, 1'b0, 5'd0,
              we, we ? 10'(32 + c - 3) : 10'd0, c == 7, c >= 8);
      n_tests++;
      if (obs(c) !== ex) begin
        n_fail++; $display("FAIL cb_pos c%0d got %h exp %h", c, obs(c), ex);
      end
    end
  endtask

  task automatic test_cb_new_neg();
    logic [45:0] ex;
    logic cb, we, s;
    run_cmd(1, CB_NEW, 10'd2, 10'h200, 10'h10, 1'b1, 6);
    for (int c = 1; c <= 6; c++) begin
      cb = (c <= 2); s = (c >= 2 && c <= 3); we = (c >= 3 && c <= 4);
      ex = pk(cb, cb ? 10'(512 + c - 1) : 10'd0, 1'b0, 10'd0,
              s ? 5'b10011 : 5'd0, s, 5'd0,
              we, we ? 10'(16 + c - 3) : 10'd0, c == 5, c >= 6);
      n_tests++;
      if (obs(c) !== ex) begin
        n_fail++; $display("FAIL cb_new c%0d got %h exp %h", c, obs(c), ex);
      end
    end
    run_cmd(1, CB_NEG, 10'd1, 10'h3FF, 10'h3FE, 1'b1, 5);
    for (int c = 1; c <= 5; c++) begin
      ex = pk(c == 1, (c == 1) ? 10'h3FF : 10'd0, 1'b0, 10'd0,
              (c == 2) ? 5'b10010 : 5'd0, 1'b0, 5'd0,
              c == 3, (c == 3) ? 10'h3FE : 10'd0, c == 4, c >= 5);
      n_tests++;
      if (obs(c) !== ex) begin
        n_fail++; $display("FAIL cb_neg c%0d got %h exp %h", c, obs(c), ex);
      end
    end
  endtask

  task automatic test_vt_wr();
    logic [45:0] ex;
    logic we, s;
    run_cmd(1, VT_WR, 10'd7, 10'd5, 10'h3FF, 1'b1, 6);
    for (int c = 1; c <= 6; c++) begin
      s = (c == 2 || c == 3); we = (c == 3 || c == 4);
      ex = pk(1'b0, 10'd0, 1'b0, 10'd0,
              s ? 5'b11100 : 5'd0, 1'b0, s ? 5'(c - 1) : 5'd0,
              we, (c == 3) ? 10'h3FF : 10'd0, c == 5, c >= 6);
      n_tests++;
      if (obs(c) !== ex) begin
        n_fail++; $display("FAIL vt_wr c%0d got %h exp %h", c, obs(c), ex);
      end
    end
    n_tests++;
    if (t_waddr[6] !== 10'h000) begin
      n_fail++; $display("FAIL vt_wr_hold got %h exp %h", t_waddr[6], 10'h000);
    end
  endtask

  task automatic test_tb_copy_lat2();
    logic [45:0] ex;
    logic tb, we;
    run_cmd(2, TB_COPY, 10'd3, 10'h100, 10'h50, 1'b0, 9);
    for (int c = 1; c <= 9; c++) begin
      tb = (c <= 3); we = (c >= 4 && c <= 6);
      ex = pk(1'b0, 10'd0, tb, tb ? 10'(256 + c - 1) : 10'd0,
              (c >= 3 && c <= 5) ? 5'b10100 : 5'd0, 1'b0, 5'd0,
              we, we ? 10'(80 + c - 4) : 10'd0, c == 7, c >= 8);
      n_tests++;
      if (obs(c) !== ex) begin
        n_fail++; $display("FAIL tb_copy c%0d got %h exp %h", c, obs(c), ex);
      end
    end
  endtask

  task automatic test_empty_illegal();
    logic [45:0] ex;
    for (int t = 0; t < 3; t++) begin
      int w, dn;
      w  = (t == 2) ? 2 : 1;
      dn = (t == 2) ? 4 : 3;
      if (t == 0)      run_cmd(1, CB_POS, 10'd0, 10'd5, 10'd9, 1'b0, 6);
      else if (t == 1) run_cmd(1, 3'd6, 10'd5, 10'd5, 10'd9, 1'b1, 6);
      else             run_cmd(2, 3'd7, 10'd3, 10'd5, 10'd9, 1'b0, 6);
      for (int c = 1; c <= 6; c++) begin
        ex = pk(1'b0, 10'd0, 1'b0, 10'd0, 5'd0, 1'b0, 5'd0, 1'b0, 10'd0, c == dn, c > dn);
        n_tests++;
        if (obs(c) !== ex) begin
          n_fail++; $display("FAIL empty%0d dut%0d c%0d got %h exp %h", t, w, c, obs(c), ex);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [45:0] ex;
    logic cb, we;
    int seen, got_c, wcnt;
    @(posedge clk); #1;
    drive_cmd(1, 1'b1, CB_POS, 10'd2, 10'd0, 10'h60, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      sample(1, c);
    end
    drive_cmd(1, 1'b0, 3'd0, '0, '0, '0, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      cb = (c <= 2) || (c == 7); we = (c == 3 || c == 4);
      ex = pk(cb, (c == 2) ? 10'd1 : 10'd0, 1'b0, 10'd0,
              (c == 2 || c == 3) ? 5'b10001 : 5'd0, 1'b0, 5'd0,
              we, we ? 10'(96 + c - 3) : 10'd0, c == 5, c == 6);
      n_tests++;
      if (obs(c) !== ex) begin
        n_fail++; $display("FAIL held_valid c%0d got %h exp %h", c, obs(c), ex);
      end
    end
    seen = 0; got_c = 0; wcnt = 0;
    for (int i = 1; i <= 20 && seen == 0; i++) begin
      @(posedge clk); #1;
      sample(1, 0);
      if (t_wea[0]) begin
        n_tests++;
        if (t_waddr[0] !== 10'(96 + wcnt)) begin
          n_fail++; $display("FAIL second_waddr got %h exp %h", t_waddr[0], 10'(96 + wcnt));
        end
        wcnt++;
      end
      if (t_done[0]) begin seen = 1; got_c = i; end
    end
    n_tests++;
    if (seen == 0 || got_c != 4) begin
      n_fail++; $display("FAIL second_done got cycle %0d exp cycle 4", got_c);
    end
    n_tests++;
    if (wcnt != 2) begin
      n_fail++; $display("FAIL second_writes got %0d exp 2", wcnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_burst();
    logic [45:0] ex;
    run_cmd(1, CB_POS, 10'd4, 10'd8, 10'h20, 1'b0, 4);
    n_tests++;
    if (t_wea[3] !== 1'b1 || t_wea[4] !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_writes got %b%b exp 11", t_wea[3], t_wea[4]);
    end
    sys_rst_n = 1'b0;
    #1;
    n_tests++;
    if (raw(1) !== 46'd1) begin
      n_fail++; $display("FAIL mid_reset got %h exp %h", raw(1), 46'd1);
    end
    @(posedge clk); #2;
    sys_rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      sample(1, c);
      ex = pk(1'b0, 10'd0, 1'b0, 10'd0, 5'd0, 1'b0, 5'd0, 1'b0, 10'd0, 1'b0, 1'b1);
      n_tests++;
      if (obs(c) !== ex) begin
        n_fail++; $display("FAIL post_reset c%0d got %h exp %h", c, obs(c), ex);
      end
    end
    run_cmd(1, CB_NEG, 10'd1, 10'h30, 10'h70, 1'b0, 5);
    for (int c = 1; c <= 5; c++) begin
      ex = pk(c == 1, (c == 1) ? 10'h30 : 10'd0, 1'b0, 10'd0,
              (c == 2) ? 5'b10010 : 5'd0, 1'b0, 5'd0,
              c == 3, (c == 3) ? 10'h70 : 10'd0, c == 4, c >= 5);
      n_tests++;
      if (obs(c) !== ex) begin
        n_fail++; $display("FAIL after_reset_cmd c%0d got %h exp %h", c, obs(c), ex);
      end
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    drive_cmd(1, 1'b0, 3'd0, '0, '0, '0, 1'b0);
    drive_cmd(2, 1'b0, 3'd0, '0, '0, '0, 1'b0);
    test_reset();
    test_cb_pos();
    test_cb_new_neg();
    test_vt_wr();
    test_tb_copy_lat2();
    test_empty_illegal();
    test_back_to_back();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
